seg7_scan_driver: RTL and testbench

//  Time-multiplexed driver for an N-digit hex seven-segment display.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/hex_to_seg7.sv | 19 +
 rtl/seg7_scan_driver.sv | 145 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared constants for the seven-segment scan driver:
//                active-low hex segment table, unlit pattern, clog2 helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

    // Segment order {g,f,e,d,c,b,a}, 0 = lit
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hex_to_seg7.sv
// ============================================================================
//  Module      : hex_to_seg7
//  Description : Combinational nibble to active-low seven-segment pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nib];

endmodule

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Time-multiplexed N-digit hex display driver with guard
//                cycle, per-digit decimal point and leading-zero blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int ACTIVE_LOW_SEG = 1,
    parameter int ACTIVE_LOW_AN  = 1,
    parameter int BLANK_LZ       = 1,
    localparam int IDX_W = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1
)(
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    ENABLE,
    input  logic                    LOAD,
    input  logic [4*NUM_DIGITS-1:0] VALUE,
    input  logic [NUM_DIGITS-1:0]   DP_IN,
    output logic [6:0]              SEG,
    output logic                    DP,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic [IDX_W-1:0]        DIGIT_IDX
);

    localparam int CNT_W = clog2(SCAN_DIV);

    localparam logic [6:0]            c_seg_unlit = (ACTIVE_LOW_SEG != 0) ? SEG_OFF : ~SEG_OFF;
    localparam logic                  c_dp_unlit  = (ACTIVE_LOW_SEG != 0);
    localparam logic [NUM_DIGITS-1:0] c_an_off    = (ACTIVE_LOW_AN != 0) ? '1 : '0;
    localparam logic [CNT_W-1:0]      c_cnt_last  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      c_idx_last  = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] r_val;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [6:0]              r_seg;
    logic                    r_dp_out;
    logic [NUM_DIGITS-1:0]   r_an;

    logic [NUM_DIGITS-1:0]   w_zero_up;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic [3:0]              w_nib;
    logic                    w_dp_sel;
    logic                    w_blank_sel;
    logic [6:0]              w_dec;
    logic [6:0]              w_seg_al;
    logic [6:0]              w_seg_nxt;
    logic                    w_dp_nxt;
    logic [NUM_DIGITS-1:0]   w_an_act;
    logic [NUM_DIGITS-1:0]   w_an_nxt;
    logic                    w_drive;

    // w_zero_up[i]: nibbles i..top all zero
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign w_zero_up[gi] = (r_val[4*gi +: 4] == 4'h0);
            end else begin : g_mid
                assign w_zero_up[gi] = (r_val[4*gi +: 4] == 4'h0) && w_zero_up[gi+1];
            end
            if (gi == 0 || BLANK_LZ == 0) begin : g_noblank
                assign w_blank[gi] = 1'b0;
            end else begin : g_blank
                assign w_blank[gi] = w_zero_up[gi] && !r_dp[gi];
            end
        end
    endgenerate

    always_comb begin
        w_nib       = 4'h0;
        w_dp_sel    = 1'b0;
        w_blank_sel = 1'b0;
        w_an_act    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib       = r_val[4*i +: 4];
                w_dp_sel    = r_dp[i];
                w_blank_sel = w_blank[i];
                w_an_act[i] = 1'b1;
            end
        end
    end

    hex_to_seg7 u_dec (
        .i_nib (w_nib),
        .o_seg (w_dec)
    );

    // Cycle 0 of every slot is a dark guard cycle to avoid ghosting
    assign w_drive   = ENABLE && (r_cnt != '0);
    assign w_seg_al  = w_blank_sel ? SEG_OFF : w_dec;
    assign w_seg_nxt = (ACTIVE_LOW_SEG != 0) ? w_seg_al : ~w_seg_al;
    assign w_dp_nxt  = (ACTIVE_LOW_SEG != 0) ? ~w_dp_sel : w_dp_sel;
    assign w_an_nxt  = (ACTIVE_LOW_AN != 0) ? ~w_an_act : w_an_act;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_val    <= '0;
            r_dp     <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_seg    <= c_seg_unlit;
            r_dp_out <= c_dp_unlit;
            r_an     <= c_an_off;
        end else begin
            if (LOAD) begin
                r_val <= VALUE;
                r_dp  <= DP_IN;
            end
            if (ENABLE) begin
                if (r_cnt == c_cnt_last) begin
                    r_cnt <= '0;
                    r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_drive) begin
                r_seg    <= w_seg_nxt;
                r_dp_out <= w_dp_nxt;
                r_an     <= w_an_nxt;
            end else begin
                r_seg    <= c_seg_unlit;
                r_dp_out <= c_dp_unlit;
                r_an     <= c_an_off;
            end
        end
    end

    assign SEG       = r_seg;
    assign DP        = r_dp_out;
    assign AN        = r_an;
    assign DIGIT_IDX = r_idx;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Directed self-checking bench for seg7_scan_driver (ND=4, DIV=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_driver;

    logic        CLK;
    logic        RESET;
    logic        ENABLE;
    logic        LOAD;
    logic [15:0] VALUE;
    logic [3:0]  DP_IN;
    logic [6:0]  SEG;
    logic        DP;
    logic [3:0]  AN;
    logic [1:0]  DIGIT_IDX;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_scan_driver #(
        .NUM_DIGITS     (4),
        .SCAN_DIV       (4),
        .ACTIVE_LOW_SEG (1),
        .ACTIVE_LOW_AN  (1),
        .BLANK_LZ       (1)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .ENABLE    (ENABLE),
        .LOAD      (LOAD),
        .VALUE     (VALUE),
        .DP_IN     (DP_IN),
        .SEG       (SEG),
        .DP        (DP),
        .AN        (AN),
        .DIGIT_IDX (DIGIT_IDX)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    // Load with the scan frozen so the slot position is unchanged
    task automatic load_idle(input logic [15:0] v, input logic [3:0] dp);
        ENABLE = 1'b0;
        LOAD   = 1'b1;
        VALUE  = v;
        DP_IN  = dp;
        tick();
        LOAD   = 1'b0;
        ENABLE = 1'b1;
    endtask

    // One full slot: guard cycle, then three drive cycles
    task automatic run_slot(input int d, input logic [6:0] seg, input logic dp);
        logic [3:0] an_exp;
        an_exp = ~(4'b0001 << d);
        tick();
        check("guard_an", 32'(AN), 32'h0000000F);
        check("slot_idx", 32'(DIGIT_IDX), 32'(d));
        for (int k = 1; k < 4; k++) begin
            tick();
            check("drive_an", 32'(AN), 32'(an_exp));
            check("drive_seg", 32'(SEG), 32'(seg));
            check("drive_dp", 32'(DP), 32'(dp));
        end
    endtask

    initial begin
        RESET  = 1'b1;
        ENABLE = 1'b0;
        LOAD   = 1'b0;
        VALUE  = 16'h0000;
        DP_IN  = 4'b0000;

        // Reset state
        do_reset();
        check("rst_an", 32'(AN), 32'h0000000F);
        check("rst_seg", 32'(SEG), 32'h0000007F);
        check("rst_dp", 32'(DP), 32'h00000001);
        check("rst_idx", 32'(DIGIT_IDX), 32'h00000000);

        // Scan of 1A3F, including wrap back to digit 0
        load_idle(16'h1A3F, 4'b0000);
        check("load_dark_an", 32'(AN), 32'h0000000F);
        run_slot(0, 7'b0001110, 1'b1);
        run_slot(1, 7'b0110000, 1'b1);
        run_slot(2, 7'b0001000, 1'b1);
        run_slot(3, 7'b1111001, 1'b1);
        run_slot(0, 7'b0001110, 1'b1);

        // Leading-zero blanking
        do_reset();
        load_idle(16'h0005, 4'b0000);
        run_slot(0, 7'b0010010, 1'b1);
        run_slot(1, 7'b1111111, 1'b1);
        run_slot(2, 7'b1111111, 1'b1);
        run_slot(3, 7'b1111111, 1'b1);
        load_idle(16'h0005, 4'b0100);
        run_slot(0, 7'b0010010, 1'b1);
        run_slot(1, 7'b1111111, 1'b1);
        run_slot(2, 7'b1000000, 1'b0);
        run_slot(3, 7'b1111111, 1'b1);

        // ENABLE drop at digit 2, cnt=2
        do_reset();
        load_idle(16'h1A3F, 4'b0000);
        run_slot(0, 7'b0001110, 1'b1);
        run_slot(1, 7'b0110000, 1'b1);
        tick();
        check("en_guard_an", 32'(AN), 32'h0000000F);
        tick();
        check("en_pre_an", 32'(AN), 32'h0000000B);
        ENABLE = 1'b0;
        tick();
        check("en_off_an", 32'(AN), 32'h0000000F);
        check("en_off_seg", 32'(SEG), 32'h0000007F);
        check("en_off_idx", 32'(DIGIT_IDX), 32'h00000002);
        tick();
        check("en_hold_idx", 32'(DIGIT_IDX), 32'h00000002);
        ENABLE = 1'b1;
        tick();
        check("en_res_an", 32'(AN), 32'h0000000B);
        check("en_res_seg", 32'(SEG), 32'h00000008);
        tick();
        check("en_res2_an", 32'(AN), 32'h0000000B);
        tick();
        check("en_next_guard", 32'(AN), 32'h0000000F);
        check("en_next_idx", 32'(DIGIT_IDX), 32'h00000003);

        // Mid-slot LOAD during digit 0 drive
        do_reset();
        load_idle(16'h0000, 4'b0000);
        tick();
        check("ml_guard_an", 32'(AN), 32'h0000000F);
        tick();
        check("ml_seg0", 32'(SEG), 32'h00000040);
        LOAD  = 1'b1;
        VALUE = 16'h0008;
        tick();
        LOAD  = 1'b0;
        check("ml_seg_old", 32'(SEG), 32'h00000040);
        tick();
        check("ml_seg_new", 32'(SEG), 32'h00000000);
        check("ml_an", 32'(AN), 32'h0000000E);

        // Reset mid-slot at digit 3, cnt=2
        do_reset();
        load_idle(16'h1A3F, 4'b0000);
        run_slot(0, 7'b0001110, 1'b1);
        run_slot(1, 7'b0110000, 1'b1);
        run_slot(2, 7'b0001000, 1'b1);
        tick();
        tick();
        check("rm_pre_an", 32'(AN), 32'h00000007);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("rm_an", 32'(AN), 32'h0000000F);
        check("rm_seg", 32'(SEG), 32'h0000007F);
        check("rm_idx", 32'(DIGIT_IDX), 32'h00000000);
        tick();
        check("rm_guard_an", 32'(AN), 32'h0000000F);
        tick();
        check("rm_d0_an", 32'(AN), 32'h0000000E);
        check("rm_d0_seg", 32'(SEG), 32'h00000040);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
